// File: rtl/display_pkg.sv
// Shared definitions for the display update scheduler: reason bit positions,
// FSM state encoding and the default watchdog budget.
package display_pkg;

   localparam int REASON_TICK = 0;
   localparam int REASON_LOAD = 1;
   localparam int REASON_MODE = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // Enough for one full shift at half the clock rate plus a small margin.
   function automatic int default_timeout(input int width);
      return (2 * width) + 8;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a one-cycle pulse
// whenever the synchronised level differs from its previous value.
module sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o,
   output logic change_o
);

   logic meta_r;
   logic sync_r;
   logic prev_r;

   // Synchroniser chain and previous-value register for edge detection
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
      end else begin
         meta_r <= async_i;
         sync_r <= meta_r;
         prev_r <= sync_r;
      end
   end

   assign sync_o   = sync_r;
   assign change_o = sync_r ^ prev_r;

endmodule

// File: rtl/display_update_scheduler.sv
// Collects tick/load/mode update requests and issues one start pulse per
// shift transaction, with coalescing, a post-latch hold-off and a watchdog.
module display_update_scheduler
   import display_pkg::*;
#(
   parameter int WIDTH   = 84,
   parameter int TIMEOUT = default_timeout(WIDTH),
   parameter int HOLDOFF = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  logic       load_i,
   input  logic       mode_i,
   input  logic       latch_i,
   output logic       start_o,
   output logic       busy_o,
   output logic [2:0] reason_o,
   output logic       overrun_o,
   output logic       timeout_o,
   output logic       mode_sync_o
);

   localparam int WD_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int HO_W = ($clog2(HOLDOFF + 1) < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1'b1);
   localparam logic [HO_W-1:0] HO_LAST = HO_W'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);
   localparam logic [HO_W-1:0] HO_ONE  = HO_W'(1'b1);
   localparam state_t POST_BUSY = (HOLDOFF == 0) ? IDLE : HOLD;

   state_t          state_r,   state_s;
   logic [2:0]      mask_r,    mask_s;
   logic [WD_W-1:0] wd_cnt_r,  wd_cnt_s;
   logic [HO_W-1:0] ho_cnt_r,  ho_cnt_s;
   logic            start_r,   start_s;
   logic            busy_r,    busy_s;
   logic [2:0]      reason_r,  reason_s;
   logic            overrun_r, overrun_s;
   logic            timeout_r, timeout_s;
   logic            mode_req_s;
   logic [2:0]      req_s;

   sync_edge u_mode_sync (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .async_i  (mode_i),
      .sync_o   (mode_sync_o),
      .change_o (mode_req_s)
   );

   // Gather this cycle's requests into reason-bit order
   always_comb begin
      req_s              = 3'b000;
      req_s[REASON_TICK] = tick_i;
      req_s[REASON_LOAD] = load_i;
      req_s[REASON_MODE] = mode_req_s;
   end

   // Next-state and next-output logic; a start clears the mask but keeps same-edge requests
   always_comb begin
      state_s   = state_r;
      mask_s    = mask_r | req_s;
      wd_cnt_s  = wd_cnt_r;
      ho_cnt_s  = ho_cnt_r;
      start_s   = 1'b0;
      busy_s    = 1'b0;
      reason_s  = reason_r;
      overrun_s = |(req_s & mask_r);
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (mask_r != 3'b000) begin
               state_s   = START;
               start_s   = 1'b1;
               busy_s    = 1'b1;
               reason_s  = mask_r;
               mask_s    = req_s;
               overrun_s = 1'b0;
               wd_cnt_s  = {WD_W{1'b0}};
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            state_s  = WAIT;
            busy_s   = 1'b1;
            wd_cnt_s = {WD_W{1'b0}};
         end
         WAIT: begin
            if (latch_i) begin
               state_s  = POST_BUSY;
               wd_cnt_s = {WD_W{1'b0}};
               ho_cnt_s = {HO_W{1'b0}};
            end else if (wd_cnt_r >= WD_LAST) begin
               // Stuck shift: abort; the counter never advances past this value
               state_s   = POST_BUSY;
               timeout_s = 1'b1;
               ho_cnt_s  = {HO_W{1'b0}};
            end else begin
               busy_s   = 1'b1;
               wd_cnt_s = wd_cnt_r + WD_ONE;
            end
         end
         HOLD: begin
            if (ho_cnt_r >= HO_LAST) begin
               state_s  = IDLE;
               ho_cnt_s = {HO_W{1'b0}};
            end else begin
               ho_cnt_s = ho_cnt_r + HO_ONE;
            end
         end
         default: begin
            state_s  = IDLE;
            wd_cnt_s = {WD_W{1'b0}};
            ho_cnt_s = {HO_W{1'b0}};
         end
      endcase
   end

   // State, counters, mask and all outputs are registered together
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         mask_r    <= 3'b000;
         wd_cnt_r  <= {WD_W{1'b0}};
         ho_cnt_r  <= {HO_W{1'b0}};
         start_r   <= 1'b0;
         busy_r    <= 1'b0;
         reason_r  <= 3'b000;
         overrun_r <= 1'b0;
         timeout_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         mask_r    <= mask_s;
         wd_cnt_r  <= wd_cnt_s;
         ho_cnt_r  <= ho_cnt_s;
         start_r   <= start_s;
         busy_r    <= busy_s;
         reason_r  <= reason_s;
         overrun_r <= overrun_s;
         timeout_r <= timeout_s;
      end
   end

   assign start_o   = start_r;
   assign busy_o    = busy_r;
   assign reason_o  = reason_r;
   assign overrun_o = overrun_r;
   assign timeout_o = timeout_r;

endmodule
